// File: rtl/tlp_win_replay.sv
// rtl/tlp_win_replay.sv - replays captured 96-bit TLP trace records onto a streaming TLP interface
//
// Purpose:
//   A replay BRAM of 2^DEPTH_W records is loaded one record at a time while idle.
//   A start pulse then streams `count` records out through a small output buffer,
//   optionally looping, under st_ready_i backpressure. Records that were not
//   accepted at capture time (bit 21 = 0) are duplicates and are dropped on
//   return from the BRAM. Each emitted beat is checked for sop/eop framing.
//
// Record format (ld_data):
//   [95:32] data, [31:24] byte enables, [23] sop, [22] eop,
//   [21] ready-at-capture, [20:0] ignored
//
// Ports:
//   trn_clk, s_rst          clock, synchronous active-high reset
//   ld_wr/ld_addr/ld_data   replay BRAM load port (honoured only while idle)
//   start/count/loop_en     replay command; count and loop_en sampled on start
//   stop                    ends a looping replay at the next packet boundary
//   st_valid_o/st_ready_i   output beat handshake
//   st_sop_o/st_eop_o       packet start/end of the current beat
//   st_be_o/st_data_o       byte enables and data of the current beat
//   busy/done               replay in progress / one-cycle completion pulse
//   frm_err/ld_err          sticky framing error / load-while-busy error
//   beat_cnt                beats accepted since last start (saturating)

module tlp_win_replay #(
    parameter int DEPTH_W = 12,
    parameter int FIFO_D  = 4
) (
    input  logic               trn_clk,
    input  logic               s_rst,
    input  logic               ld_wr,
    input  logic [DEPTH_W-1:0] ld_addr,
    input  logic [95:0]        ld_data,
    input  logic               start,
    input  logic [DEPTH_W:0]   count,
    input  logic               loop_en,
    input  logic               stop,
    output logic               st_valid_o,
    input  logic               st_ready_i,
    output logic               st_sop_o,
    output logic               st_eop_o,
    output logic [7:0]         st_be_o,
    output logic [63:0]        st_data_o,
    output logic               busy,
    output logic               done,
    output logic               frm_err,
    output logic               ld_err,
    output logic [15:0]        beat_cnt
);

    localparam int FA_W = $clog2(FIFO_D);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q;
    logic               busy_q;
    logic               done_q;
    logic               frm_err_q;
    logic               ld_err_q;
    logic [15:0]        beat_cnt_q;
    logic [DEPTH_W:0]   count_q;
    logic               loop_q;
    logic [DEPTH_W:0]   rd_idx_q;
    logic               stop_pend_q;
    logic               in_pkt_q;

    // BRAM read pipeline: rd_vld_q marks a record returning this cycle
    logic [95:0]        bram_q [2**DEPTH_W];
    logic [95:0]        rd_rec_q;
    logic               rd_vld_q;

    // Output buffer: entries are {data[63:0], be[7:0], sop, eop}
    logic [73:0]        fifo_q [FIFO_D];
    logic [FA_W-1:0]    wr_p_q;
    logic [FA_W-1:0]    rd_p_q;
    logic [FA_W:0]      occ_q;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic        push;
    logic        pop;
    logic        fifo_valid;
    logic [73:0] head;
    logic        stop_req;
    logic        stop_hit;
    logic        room;
    logic        rd_en;
    logic        last_rd;
    logic        drain_fin;
    logic        start_ok;
    logic        unused_rec;

    assign fifo_valid = (occ_q != '0);
    assign head       = fifo_q[rd_p_q];
    assign pop        = fifo_valid && st_ready_i;
    // Records not accepted at capture time were re-presented by the source;
    // only the accepted copy is replayed.
    assign push       = rd_vld_q && rd_rec_q[21];

    // A stop pulse arriving in the same cycle as a qualifying eop record
    // still takes effect on that record.
    assign stop_req   = stop_pend_q || (stop && loop_q && (state_q == S_RUN));
    assign stop_hit   = (state_q == S_RUN) && stop_req && rd_vld_q
                        && rd_rec_q[22] && rd_rec_q[21];

    // Reserve a buffer slot for every read in flight so returned records
    // always have somewhere to land.
    assign room       = (int'(occ_q) + int'(rd_vld_q)) < FIFO_D;
    // No read is issued in the cycle the stopping eop returns, so nothing
    // beyond the packet boundary is ever fetched.
    assign rd_en      = (state_q == S_RUN) && room && !stop_hit;
    assign last_rd    = (rd_idx_q == (count_q - 1'b1));

    // Completion is predicted one cycle early so done lands in the cycle
    // after the final pop while remaining a registered output.
    assign drain_fin  = (state_q == S_DRAIN) && !rd_vld_q
                        && ((occ_q == '0) || ((occ_q == 1) && pop));

    // done_q is only high in the first idle cycle; a start there is dropped.
    assign start_ok   = start && (state_q == S_IDLE) && !done_q;

    assign unused_rec = ^rd_rec_q[20:0];

    // ------------------------------------------------------------------
    // Replay BRAM: write port while idle, one-cycle registered read
    // ------------------------------------------------------------------
    always_ff @(posedge trn_clk) begin
        if (ld_wr && (state_q == S_IDLE)) begin
            bram_q[ld_addr] <= ld_data;
        end
        if (rd_en) begin
            rd_rec_q <= bram_q[rd_idx_q[DEPTH_W-1:0]];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge trn_clk) begin
        if (s_rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frm_err_q   <= 1'b0;
            ld_err_q    <= 1'b0;
            beat_cnt_q  <= '0;
            count_q     <= '0;
            loop_q      <= 1'b0;
            rd_idx_q    <= '0;
            stop_pend_q <= 1'b0;
            in_pkt_q    <= 1'b0;
            rd_vld_q    <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            rd_vld_q <= rd_en;

            if (ld_wr && (state_q != S_IDLE)) begin
                ld_err_q <= 1'b1;
            end

            if (pop) begin
                if (beat_cnt_q != 16'hFFFF) begin
                    beat_cnt_q <= beat_cnt_q + 16'd1;
                end
                // head[1] = sop, head[0] = eop
                if ((head[1] && in_pkt_q) || (!head[1] && !in_pkt_q)) begin
                    frm_err_q <= 1'b1;
                end
                if (head[0]) begin
                    in_pkt_q <= 1'b0;
                end else if (head[1]) begin
                    in_pkt_q <= 1'b1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        count_q     <= count;
                        loop_q      <= loop_en;
                        beat_cnt_q  <= '0;
                        frm_err_q   <= 1'b0;
                        ld_err_q    <= 1'b0;
                        rd_idx_q    <= '0;
                        stop_pend_q <= 1'b0;
                        in_pkt_q    <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= (count == '0) ? S_DRAIN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (stop && loop_q) begin
                        stop_pend_q <= 1'b1;
                    end
                    if (stop_hit) begin
                        state_q <= S_DRAIN;
                    end else if (rd_en) begin
                        if (last_rd) begin
                            if (loop_q) begin
                                rd_idx_q <= '0;
                            end else begin
                                state_q <= S_DRAIN;
                            end
                        end else begin
                            rd_idx_q <= rd_idx_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_fin) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output buffer
    // ------------------------------------------------------------------
    always_ff @(posedge trn_clk) begin
        if (push) begin
            fifo_q[wr_p_q] <= rd_rec_q[95:22];
        end
    end

    always_ff @(posedge trn_clk) begin
        if (s_rst) begin
            wr_p_q <= '0;
            rd_p_q <= '0;
            occ_q  <= '0;
        end else begin
            if (push) begin
                wr_p_q <= wr_p_q + 1'b1;
            end
            if (pop) begin
                rd_p_q <= rd_p_q + 1'b1;
            end
            occ_q <= occ_q + {{FA_W{1'b0}}, push} - {{FA_W{1'b0}}, pop};
        end
    end

    // ------------------------------------------------------------------
    // Outputs: beat fields are forced to zero whenever nothing is valid
    // ------------------------------------------------------------------
    assign st_valid_o = fifo_valid;
    assign st_data_o  = fifo_valid ? head[73:10] : 64'd0;
    assign st_be_o    = fifo_valid ? head[9:2]   : 8'd0;
    assign st_sop_o   = fifo_valid && head[1];
    assign st_eop_o   = fifo_valid && head[0];

    assign busy       = busy_q;
    assign done       = done_q;
    assign frm_err    = frm_err_q;
    assign ld_err     = ld_err_q;
    assign beat_cnt   = beat_cnt_q;

endmodule
